// File: rtl/counter_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : counter_seq_pkg
// Purpose  : Shared types and encodings for the counter run sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package counter_seq_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        MODE_FREE    = 2'b00,
        MODE_ONESHOT = 2'b01,
        MODE_RELOAD  = 2'b10
    } mode_t;

    // The unused 2'b11 encoding behaves as a one-shot run.
    function automatic mode_t decode_mode(input logic [1:0] raw);
        mode_t m;
        case (raw)
            2'b00:   m = MODE_FREE;
            2'b10:   m = MODE_RELOAD;
            default: m = MODE_ONESHOT;
        endcase
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_event_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_event_counter
// Purpose  : Event counter with synchronous clear that sticks at all-ones.
// Revision : 1.0 - initial release
// ============================================================================
module sat_event_counter #(
    parameter int EVT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [EVT_W-1:0] count
);

    localparam logic [EVT_W-1:0] c_one = EVT_W'(1);

    logic [EVT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + c_one;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/counter_run_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : counter_run_sequencer
// Purpose  : Drives the up-counter's en/load/oe controls for free-run,
//            one-shot and auto-reload runs, watching the fed-back count.
// Revision : 1.0 - initial release
// ============================================================================
module counter_run_sequencer
    import counter_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int EVT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] start_val,
    input  logic [WIDTH-1:0] end_val,
    input  logic [WIDTH-1:0] cnt_in,
    output logic             cnt_en,
    output logic             cnt_load,
    output logic [WIDTH-1:0] load_data,
    output logic             cnt_oe,
    output logic             busy,
    output logic             done,
    output logic [EVT_W-1:0] evt_cnt
);

    state_t           r_state;
    state_t           w_next;
    mode_t            r_mode;
    logic [WIDTH-1:0] r_start_val;
    logic [WIDTH-1:0] r_end_val;
    logic [WIDTH-1:0] w_load_data;
    logic             w_term;
    logic             w_cnt_en;
    logic             w_cnt_load;
    logic             w_cnt_oe;
    logic             w_done;
    logic             w_evt_inc;
    logic             w_evt_clr;
    logic             w_latch;

    assign w_term = (cnt_in == r_end_val);

    always_comb begin
        w_next      = r_state;
        w_load_data = r_start_val;
        w_cnt_en    = 1'b0;
        w_cnt_load  = 1'b0;
        w_cnt_oe    = 1'b0;
        w_done      = 1'b0;
        w_evt_inc   = 1'b0;
        w_evt_clr   = 1'b0;
        w_latch     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_load_data = start_val;
                if (start && !stop) begin
                    w_next    = ST_LOAD;
                    w_evt_clr = 1'b1;
                    w_latch   = 1'b1;
                end
            end
            ST_LOAD: begin
                w_cnt_oe = 1'b1;
                if (stop) begin
                    w_next = ST_IDLE;
                end else begin
                    w_cnt_load = 1'b1;
                    w_next     = ST_RUN;
                end
            end
            ST_RUN: begin
                w_cnt_oe = 1'b1;
                // Terminal action outranks pause; FREE never terminates.
                if (stop) begin
                    w_next = ST_IDLE;
                end else if (w_term && (r_mode != MODE_FREE)) begin
                    if (r_mode == MODE_RELOAD) begin
                        w_next    = ST_LOAD;
                        w_evt_inc = 1'b1;
                    end else begin
                        w_next = ST_DONE;
                    end
                end else if (pause) begin
                    w_next = ST_PAUSE;
                end else begin
                    w_cnt_en  = 1'b1;
                    w_evt_inc = (r_mode == MODE_FREE) && (cnt_in == '1);
                end
            end
            ST_PAUSE: begin
                w_cnt_oe = 1'b1;
                if (stop) begin
                    w_next = ST_IDLE;
                end else if (!pause) begin
                    w_next = ST_RUN;
                end
            end
            ST_DONE: begin
                w_cnt_oe = 1'b1;
                w_done   = !stop;
                w_next   = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
        // Deselected: everything freezes in place.
        if (!ena) begin
            w_next    = r_state;
            w_evt_inc = 1'b0;
            w_evt_clr = 1'b0;
            w_latch   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_mode      <= MODE_FREE;
            r_start_val <= '0;
            r_end_val   <= '0;
        end else begin
            r_state <= w_next;
            if (w_latch) begin
                r_mode      <= decode_mode(mode);
                r_start_val <= start_val;
                r_end_val   <= end_val;
            end
        end
    end

    sat_event_counter #(
        .EVT_W (EVT_W)
    ) u_evt (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_evt_clr),
        .inc   (w_evt_inc),
        .count (evt_cnt)
    );

    assign cnt_en    = w_cnt_en & ena;
    assign cnt_load  = w_cnt_load & ena;
    assign load_data = w_load_data & {WIDTH{ena}};
    assign cnt_oe    = w_cnt_oe & ena;
    assign busy      = (r_state != ST_IDLE) & ena;
    assign done      = w_done & ena;

endmodule
`default_nettype wire

// File: tb/tb_counter_run_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_run_sequencer
// Purpose  : Randomized self-checking bench with an arithmetic run model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_counter_run_sequencer;

    logic       clk = 1'b0;
    logic       rst, ena, start, stop, pause;
    logic [1:0] mode;
    logic [7:0] start_val, end_val;
    logic [7:0] cnt, cnt2;
    logic       cnt_en, cnt_load, cnt_oe, busy, done;
    logic [7:0] load_data, evt_cnt;
    logic       cnt_en2, cnt_load2, cnt_oe2, busy2, done2;
    logic [7:0] load_data2;
    logic [1:0] evt_cnt2;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    counter_run_sequencer #(.WIDTH(8), .EVT_W(8)) dut (
        .clk(clk), .rst(rst), .ena(ena), .start(start), .stop(stop), .pause(pause),
        .mode(mode), .start_val(start_val), .end_val(end_val), .cnt_in(cnt),
        .cnt_en(cnt_en), .cnt_load(cnt_load), .load_data(load_data), .cnt_oe(cnt_oe),
        .busy(busy), .done(done), .evt_cnt(evt_cnt)
    );

    counter_run_sequencer #(.WIDTH(8), .EVT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .ena(ena), .start(start), .stop(stop), .pause(pause),
        .mode(mode), .start_val(start_val), .end_val(end_val), .cnt_in(cnt2),
        .cnt_en(cnt_en2), .cnt_load(cnt_load2), .load_data(load_data2), .cnt_oe(cnt_oe2),
        .busy(busy2), .done(done2), .evt_cnt(evt_cnt2)
    );

    // Behavioural stand-ins for the team's up-counter.
    always_ff @(posedge clk) begin
        if (rst)           cnt <= 8'h00;
        else if (cnt_load) cnt <= load_data;
        else if (cnt_en)   cnt <= cnt + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst)            cnt2 <= 8'h00;
        else if (cnt_load2) cnt2 <= load_data2;
        else if (cnt_en2)   cnt2 <= cnt2 + 8'd1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic go_idle();
        start = 1'b0; stop = 1'b1; pause = 1'b0;
        @(negedge clk);
        tick();
        stop = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL go_idle busy got %b exp 0", busy);
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; ena = 1'b1; stop = 1'b0;
        start = 1'($urandom); pause = 1'($urandom); mode = 2'($urandom);
        start_val = 8'h00; end_val = 8'($urandom);
        tick(); tick();
        @(negedge clk);
        checks++;
        if ({cnt_en, cnt_load, cnt_oe, busy, done} !== 5'b0 || load_data !== 8'h00 || evt_cnt !== 8'h00) begin
            errors++;
            $display("FAIL reset en/ld/oe/busy/done got %b data %h evt %h exp 0",
                     {cnt_en, cnt_load, cnt_oe, busy, done}, load_data, evt_cnt);
        end
        rst = 1'b0; start = 1'b0; pause = 1'b0;
        tick();
    endtask

    // One-shot: n = (end - start) mod 256 increments, done 3 + n cycles after start.
    task automatic run_oneshot(input logic [7:0] s, input logic [7:0] e, input logic [1:0] m);
        int n;
        logic [4:0] exp_v;
        logic [7:0] exp_c;
        n = int'(8'(e - s));
        for (int k = 0; k <= n + 5; k++) begin
            start = (k == 0); stop = 1'b0; pause = 1'b0;
            if (k == 0) begin
                mode = m; start_val = s; end_val = e;
            end else begin
                mode = 2'($urandom); start_val = 8'($urandom); end_val = 8'($urandom);
            end
            @(negedge clk);
            exp_v = {k == 1, (k >= 2) && (k < 2 + n), k == n + 3,
                     (k >= 1) && (k <= n + 3), (k >= 1) && (k <= n + 3)};
            checks++;
            if ({cnt_load, cnt_en, done, busy, cnt_oe} !== exp_v) begin
                errors++;
                $display("FAIL oneshot ld/en/done/busy/oe s=%h e=%h k=%0d got %b exp %b",
                         s, e, k, {cnt_load, cnt_en, done, busy, cnt_oe}, exp_v);
            end
            if (k == 1) begin
                checks++;
                if (load_data !== s) begin
                    errors++; $display("FAIL oneshot load_data got %h exp %h", load_data, s);
                end
            end
            if (k >= 2) begin
                exp_c = 8'(s + sat(k - 2, n));
                checks++;
                if (cnt !== exp_c || evt_cnt !== 8'h00) begin
                    errors++;
                    $display("FAIL oneshot cnt/evt s=%h e=%h k=%0d got %h/%h exp %h/00",
                             s, e, k, cnt, evt_cnt, exp_c);
                end
            end
            tick();
        end
    endtask

    task automatic test_oneshot();
        logic [7:0] s;
        run_oneshot(8'h05, 8'h08, 2'b01);
        run_oneshot(8'hFD, 8'h01, 2'b01);
        s = 8'($urandom);
        run_oneshot(s, s, 2'b01);
        for (int i = 0; i < 3; i++) begin
            s = 8'($urandom);
            run_oneshot(s, 8'($urandom), (i == 0) ? 2'b11 : 2'b01);
        end
    endtask

    // Reload: period n+2 (one LOAD + n+1 RUN cycles), one event per period.
    task automatic run_reload(input logic [7:0] s, input int n, input int cycles);
        int         p, ph;
        logic [7:0] e;
        logic [1:0] exp_v;
        logic [7:0] exp_c;
        e = 8'(s + n);
        p = n + 2;
        for (int k = 0; k <= cycles + 1; k++) begin
            start = (k == 0); stop = (k == cycles); pause = 1'b0;
            if (k == 0) begin
                mode = 2'b10; start_val = s; end_val = e;
            end else begin
                mode = 2'($urandom); start_val = 8'($urandom); end_val = 8'($urandom);
            end
            @(negedge clk);
            ph = (k >= 1) ? (k - 1) % p : 0;
            if (k >= 1 && k <= cycles) begin
                exp_v = {(k < cycles) && (ph == 0), (k < cycles) && (ph >= 1) && (ph - 1 < n)};
                checks++;
                if ({cnt_load, cnt_en} !== exp_v || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL reload ld/en/busy s=%h n=%0d k=%0d got %b%b exp %b1",
                             s, n, k, {cnt_load, cnt_en}, busy, exp_v);
                end
                if (k >= 2) begin
                    exp_c = (ph == 0) ? e : 8'(s + ph - 1);
                    checks++;
                    if (cnt !== exp_c) begin
                        errors++; $display("FAIL reload cnt k=%0d got %h exp %h", k, cnt, exp_c);
                    end
                end
                checks++;
                if (evt_cnt !== 8'(sat((k - 1) / p, 255)) || evt_cnt2 !== 2'(sat((k - 1) / p, 3))) begin
                    errors++;
                    $display("FAIL reload evt k=%0d got %0d/%0d exp %0d", k, evt_cnt, evt_cnt2, (k - 1) / p);
                end
            end
            if (k == cycles + 1) begin
                checks++;
                if (busy !== 1'b0 || evt_cnt !== 8'(sat((cycles - 1) / p, 255))) begin
                    errors++;
                    $display("FAIL reload after_stop busy/evt got %b/%0d exp 0/%0d",
                             busy, evt_cnt, (cycles - 1) / p);
                end
            end
            tick();
        end
        stop = 1'b0;
    endtask

    task automatic test_reload();
        run_reload(8'h10, 2, 20);
        run_reload(8'($urandom), 0, 12);
        run_reload(8'($urandom), int'($urandom_range(1, 5)), 25);
    endtask

    // Free-run: counting enabled when pause is low this cycle and the last.
    task automatic run_free(input logic [7:0] s, input bit fixed_pause, input int cycles);
        logic [7:0] v;
        bit         p, prevp, exp_en;
        int         wraps;
        v = s; prevp = 1'b0; wraps = 0;
        for (int k = 0; k <= cycles + 1; k++) begin
            start = (k == 0); stop = (k == cycles);
            if (k < 2 || k >= cycles) p = 1'b0;
            else if (fixed_pause)     p = (k >= 6) && (k <= 8);
            else                      p = ($urandom_range(0, 3) == 0);
            pause = p;
            end_val = 8'($urandom);
            if (k == 0) begin
                mode = 2'b00; start_val = s;
            end else begin
                mode = 2'($urandom); start_val = 8'($urandom);
            end
            @(negedge clk);
            if (k == 1) begin
                checks++;
                if (cnt_load !== 1'b1 || load_data !== s) begin
                    errors++; $display("FAIL free load got %b/%h exp 1/%h", cnt_load, load_data, s);
                end
            end
            if (k >= 2 && k < cycles) begin
                exp_en = !p && !prevp;
                checks++;
                if (cnt !== v || cnt_en !== exp_en || evt_cnt !== 8'(sat(wraps, 255)) ||
                    evt_cnt2 !== 2'(sat(wraps, 3))) begin
                    errors++;
                    $display("FAIL free cnt/en/evt k=%0d got %h/%b/%0d/%0d exp %h/%b/%0d",
                             k, cnt, cnt_en, evt_cnt, evt_cnt2, v, exp_en, wraps);
                end
                if (exp_en) begin
                    if (v == 8'hFF) wraps++;
                    v = v + 8'd1;
                end
            end
            if (k == cycles) begin
                checks++;
                if (cnt_en !== 1'b0 || cnt_load !== 1'b0) begin
                    errors++; $display("FAIL free stop_strobe got %b%b exp 00", cnt_en, cnt_load);
                end
            end
            if (k == cycles + 1) begin
                checks++;
                if (busy !== 1'b0 || cnt !== v) begin
                    errors++; $display("FAIL free after_stop busy/cnt got %b/%h exp 0/%h", busy, cnt, v);
                end
            end
            prevp = p;
            tick();
        end
        stop = 1'b0;
    endtask

    task automatic test_free();
        run_free(8'hFE, 1'b1, 16);
        run_free(8'($urandom_range(200, 255)), 1'b0, 60);
        run_free(8'($urandom), 1'b0, 300);
    endtask

    task automatic test_stop();
        logic [7:0] s, exp_c;
        int         ks;
        s = 8'($urandom);
        ks = int'($urandom_range(2, 20));
        exp_c = 8'(s + ks - 2);
        for (int k = 0; k <= ks + 5; k++) begin
            start = (k == 0); stop = (k == ks); pause = 1'b0;
            mode = 2'b01; start_val = s; end_val = 8'(s + 100);
            @(negedge clk);
            if (k == ks) begin
                checks++;
                if ({cnt_en, cnt_load, done, busy} !== 4'b0001) begin
                    errors++; $display("FAIL stop_cycle en/ld/done/busy got %b exp 0001",
                                       {cnt_en, cnt_load, done, busy});
                end
            end
            if (k > ks) begin
                checks++;
                if (busy !== 1'b0 || done !== 1'b0 || cnt !== exp_c) begin
                    errors++; $display("FAIL stop_after k=%0d busy/done/cnt got %b/%b/%h exp 0/0/%h",
                                       k, busy, done, cnt, exp_c);
                end
            end
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            start = 1'b1; stop = 1'b1;
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || cnt_load !== 1'b0) begin
                errors++; $display("FAIL start_stop_idle busy/ld got %b/%b exp 0/0", busy, cnt_load);
            end
            tick();
        end
        start = 1'b0; stop = 1'b0;
    endtask

    task automatic test_relaunch();
        logic [7:0] s;
        logic [3:0] exp_v;
        s = 8'($urandom);
        for (int k = 0; k <= 6; k++) begin
            start = 1'b1; stop = 1'b0; pause = 1'b0;
            mode = 2'b01; start_val = s; end_val = s;
            @(negedge clk);
            exp_v = {(k == 1) || (k == 5), 1'b0, k == 3,
                     ((k >= 1) && (k <= 3)) || (k >= 5)};
            checks++;
            if ({cnt_load, cnt_en, done, busy} !== exp_v) begin
                errors++; $display("FAIL relaunch k=%0d ld/en/done/busy got %b exp %b",
                                   k, {cnt_load, cnt_en, done, busy}, exp_v);
            end
            tick();
        end
        go_idle();
    endtask

    task automatic test_rst_ena();
        for (int k = 0; k <= 13; k++) begin
            start = (k == 0) || (k == 12); stop = 1'b0; pause = 1'b0;
            mode = 2'b00; start_val = (k == 0) ? 8'hFE : 8'h00; end_val = 8'($urandom);
            ena = !((k >= 6) && (k <= 9));
            rst = (k == 12);
            @(negedge clk);
            if (k >= 6 && k <= 9) begin
                checks++;
                if (cnt_en !== 1'b0 || cnt_load !== 1'b0 || cnt !== 8'h02 || evt_cnt !== 8'd1) begin
                    errors++; $display("FAIL ena_low k=%0d en/ld/cnt/evt got %b/%b/%h/%0d exp 0/0/02/1",
                                       k, cnt_en, cnt_load, cnt, evt_cnt);
                end
            end
            if (k == 10 || k == 11) begin
                checks++;
                if (cnt_en !== 1'b1 || busy !== 1'b1 || cnt !== 8'(k - 8)) begin
                    errors++; $display("FAIL ena_resume k=%0d en/busy/cnt got %b/%b/%h exp 1/1/%h",
                                       k, cnt_en, busy, cnt, 8'(k - 8));
                end
            end
            if (k == 13) begin
                checks++;
                if ({cnt_en, cnt_load, cnt_oe, busy, done} !== 5'b0 || load_data !== 8'h00 ||
                    evt_cnt !== 8'h00) begin
                    errors++; $display("FAIL rst_midrun got %b data %h evt %h exp 0",
                                       {cnt_en, cnt_load, cnt_oe, busy, done}, load_data, evt_cnt);
                end
            end
            tick();
        end
        start = 1'b0; rst = 1'b0; ena = 1'b1;
    endtask

    initial begin
        rst = 1'b1; ena = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
        mode = 2'b00; start_val = 8'h00; end_val = 8'h00;
        test_reset();
        test_oneshot();
        test_reload();
        test_free();
        test_stop();
        test_relaunch();
        test_rst_ena();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
